// File: rtl/note_sequencer_if.sv
// Bundle of the sequencer's control, note-memory read port and tone-generator signals.
// The master modport is the sequencer; the slave side is the player/memory/tone environment.
interface note_sequencer_if #(
    parameter int ADDR_W = 7
);
    logic              play;
    logic              stop;
    logic              loop_en;
    logic [31:0]       tempo;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_freq;
    logic [2:0]        mem_h;
    logic [7:0]        mem_len;
    logic [3:0]        freq;
    logic [2:0]        h;
    logic              playing;
    logic              paused;
    logic              done;

    modport master (
        input  play, stop, loop_en, tempo, mem_freq, mem_h, mem_len,
        output mem_addr, freq, h, playing, paused, done
    );

    modport slave (
        output play, stop, loop_en, tempo, mem_freq, mem_h, mem_len,
        input  mem_addr, freq, h, playing, paused, done
    );
endinterface

// File: rtl/note_sequencer.sv
// Song playback controller: walks note memory, times each note from the tempo with a
// trailing mute gap, and supports play/pause/stop, end-of-song detection and looping.
module note_sequencer #(
    parameter int          ADDR_W    = 7,
    parameter int unsigned GAP_CYC   = 500,
    parameter logic [3:0]  MUTE_CODE = 4'hC,
    parameter logic [3:0]  END_CODE  = 4'hF
) (
    input  logic            dclk12,
    input  logic            rst,
    note_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SOUND,
        S_GAP,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [31:0]       GAP_W    = 32'(GAP_CYC);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state_q, state_d;
    state_t            saved_q, saved_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       dur_q, dur_d;
    logic [3:0]        note_freq_q, note_freq_d;
    logic [2:0]        note_h_q, note_h_d;
    logic [3:0]        freq_q, freq_d;
    logic [2:0]        h_q, h_d;
    logic              playing_q, playing_d;
    logic              paused_q, paused_d;
    logic              done_q, done_d;

    logic [31:0]       dur_raw;
    logic [31:0]       dur_calc;
    logic [31:0]       third;
    logic [31:0]       half;
    logic              end_song;

    // Length code to cycle count; every product wraps at 32 bits and a zero result becomes 1.
    always_comb begin
        third   = bus.tempo / 32'd3;
        half    = bus.tempo >> 1;
        dur_raw = bus.tempo;
        case (bus.mem_len)
            8'h01:   dur_raw = third << 1;
            8'h02:   dur_raw = third;
            8'h04:   dur_raw = bus.tempo >> 2;
            8'h08:   dur_raw = half;
            8'h10:   dur_raw = bus.tempo;
            8'h20:   dur_raw = half + (half << 1);
            8'h40:   dur_raw = bus.tempo << 1;
            8'h80:   dur_raw = bus.tempo + (bus.tempo << 1);
            default: dur_raw = bus.tempo;
        endcase
        dur_calc = (dur_raw == 32'd0) ? 32'd1 : dur_raw;
    end

    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        dur_d       = dur_q;
        note_freq_d = note_freq_q;
        note_h_d    = note_h_q;
        h_d         = h_q;
        end_song    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.play) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.play) begin
                    state_d = S_PAUSE;
                    saved_d = S_FETCH;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // A pause here discards the in-flight read; resuming re-fetches the slot.
                if (bus.play) begin
                    state_d = S_PAUSE;
                    saved_d = S_FETCH;
                end else begin
                    note_freq_d = bus.mem_freq;
                    note_h_d    = bus.mem_h;
                    dur_d       = dur_calc;
                    cnt_d       = 32'd0;
                    if (bus.mem_freq == END_CODE) begin
                        end_song = 1'b1;
                    end else begin
                        h_d     = bus.mem_h;
                        state_d = (dur_calc > GAP_W) ? S_SOUND : S_GAP;
                    end
                end
            end
            S_SOUND: begin
                if (bus.play) begin
                    state_d = S_PAUSE;
                    saved_d = S_SOUND;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q == dur_q - GAP_W - 32'd1) state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (bus.play) begin
                    state_d = S_PAUSE;
                    saved_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q == dur_q - 32'd1) begin
                        if (addr_q == ADDR_MAX) begin
                            end_song = 1'b1;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (bus.play) state_d = saved_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (end_song) begin
            addr_d  = '0;
            state_d = bus.loop_en ? S_FETCH : S_DONE;
        end

        // Stop overrides every other request, including a simultaneous play.
        if (bus.stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end

        freq_d    = (state_d == S_SOUND) ? note_freq_d : MUTE_CODE;
        playing_d = state_d inside {S_FETCH, S_LOAD, S_SOUND, S_GAP, S_PAUSE};
        paused_d  = (state_d == S_PAUSE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge dclk12) begin
        if (rst) begin
            state_q     <= S_IDLE;
            saved_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= 32'd0;
            dur_q       <= 32'd0;
            note_freq_q <= MUTE_CODE;
            note_h_q    <= 3'd0;
            freq_q      <= MUTE_CODE;
            h_q         <= 3'd0;
            playing_q   <= 1'b0;
            paused_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            dur_q       <= dur_d;
            note_freq_q <= note_freq_d;
            note_h_q    <= note_h_d;
            freq_q      <= freq_d;
            h_q         <= h_d;
            playing_q   <= playing_d;
            paused_q    <= paused_d;
            done_q      <= done_d;
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.freq     = freq_q;
    assign bus.h        = h_q;
    assign bus.playing  = playing_q;
    assign bus.paused   = paused_q;
    assign bus.done     = done_q;

endmodule
